// File: rtl/async_receiver.sv
// async_receiver: 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error detection.
module async_receiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       FPGA_CLK1_50,
  input  logic       reset_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_framing_err,
  output logic       RxD_busy
);
  localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW = $clog2(10 * BIT_CYCLES + 1);
  localparam logic [CW-1:0] START_PT = CW'(HALF - 1);
  localparam logic [CW-1:0] STOP_PT = CW'(HALF - 1 + 9 * BIT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, smp_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          stop_q, ready_q, err_q;
  logic          rxd_s, hit;

  assign rxd_s = sync_q[1];
  assign hit = cnt_q == smp_q;
  assign RxD_data = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_framing_err = err_q;
  assign RxD_busy = state_q != IDLE;

  // Resetting the synchronizer high keeps reset release from looking like a start bit.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n)
    if (!reset_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], RxD};

  // cnt_q counts cycles since the start edge; smp_q holds the count of the next sample point.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= state_q == IDLE ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          smp_q <= START_PT;
          bit_q <= '0;
          if (!rxd_s) state_q <= START;
        end
        START: if (hit) begin
          state_q <= rxd_s ? IDLE : DATA;
          smp_q   <= smp_q + CW'(BIT_CYCLES);
        end
        DATA: if (hit) begin
          shift_q <= {rxd_s, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
          smp_q   <= smp_q + CW'(BIT_CYCLES);
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (hit) begin
          if (cnt_q == STOP_PT) begin
            stop_q <= rxd_s;
            smp_q  <= smp_q + CW'(1);
          end else begin
            ready_q <= stop_q;
            err_q   <= !stop_q;
            if (stop_q) data_q <= shift_q;
            state_q <= stop_q ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rxd_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_async_receiver.sv
// tb_async_receiver: scenario tasks checked against a line-waveform reference model of the receiver.
module tb_async_receiver;
  localparam int BC = 10, HF = 5, DBC = 434, DHF = 217, LAT = 3;

  logic clk = 1'b0, reset_n = 1'b0, rxd = 1'b1, rxd_def = 1'b1;
  logic [7:0] data, data_def;
  logic ready, err, busy, ready_def, err_def, busy_def;
  int checks = 0, errors = 0, first_bad = -1;
  logic [7:0] cur_data = 8'h00;

  bit line[$];
  logic o_ready[$], o_err[$], o_busy[$];
  logic [7:0] o_data[$];
  logic e_ready[$], e_err[$], e_busy[$];
  logic [7:0] e_data[$];

  always #5 clk = ~clk;

  async_receiver #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .FPGA_CLK1_50(clk), .reset_n(reset_n), .RxD(rxd), .RxD_data(data),
    .RxD_data_ready(ready), .RxD_framing_err(err), .RxD_busy(busy)
  );

  async_receiver u_def (
    .FPGA_CLK1_50(clk), .reset_n(reset_n), .RxD(rxd_def), .RxD_data(data_def),
    .RxD_data_ready(ready_def), .RxD_framing_err(err_def), .RxD_busy(busy_def)
  );

  task automatic add_level(input bit v, input int n);
    repeat (n) line.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop, input int bc);
    add_level(1'b0, bc);
    for (int i = 0; i < 8; i++) add_level(b[i], bc);
    add_level(stop, bc);
  endtask

  // The receiver decides at clock edge k on line value k-LAT (two sync flops plus the FSM edge).
  function automatic bit rs(input int k);
    return (k >= LAT && k - LAT < line.size()) ? line[k-LAT] : 1'b1;
  endfunction

  task automatic model(input int bc, input int hf, input logic [7:0] d0);
    int n, k, e, j;
    logic [7:0] b;
    n = line.size();
    k = 0;
    e_ready.delete(); e_err.delete(); e_busy.delete(); e_data.delete();
    for (int i = 0; i < n; i++) begin
      e_ready.push_back(1'b0); e_err.push_back(1'b0); e_busy.push_back(1'b0); e_data.push_back(d0);
    end
    while (k < n) begin
      if (rs(k)) begin
        k++;
        continue;
      end
      if (rs(k + hf)) begin
        for (int m = k; m < k + hf && m < n; m++) e_busy[m] = 1'b1;
        k = k + hf + 1;
        continue;
      end
      for (int i = 0; i < 8; i++) b[i] = rs(k + hf + (i + 1) * bc);
      e = k + hf + 9 * bc + 1;
      for (int m = k; m < e && m < n; m++) e_busy[m] = 1'b1;
      if (e >= n) break;
      if (rs(e - 1)) begin
        e_ready[e] = 1'b1;
        for (int m = e; m < n; m++) e_data[m] = b;
        k = e + 1;
      end else begin
        e_err[e] = 1'b1;
        j = e + 1;
        while (j < n && !rs(j)) j++;
        for (int m = e; m < j && m < n; m++) e_busy[m] = 1'b1;
        k = j + 1;
      end
    end
  endtask

  task automatic run_stream(input bit def);
    o_ready.delete(); o_err.delete(); o_busy.delete(); o_data.delete();
    for (int i = 0; i < line.size(); i++) begin
      @(negedge clk);
      o_ready.push_back(def ? ready_def : ready);
      o_err.push_back(def ? err_def : err);
      o_busy.push_back(def ? busy_def : busy);
      o_data.push_back(def ? data_def : data);
      if (def) rxd_def = line[i];
      else rxd = line[i];
    end
  endtask

  function automatic logic [10:0] obs_at(input int i);
    return {o_ready[i], o_err[i], o_busy[i], o_data[i]};
  endfunction

  function automatic logic [10:0] exp_at(input int i);
    return {e_ready[i], e_err[i], e_busy[i], e_data[i]};
  endfunction

  function automatic int mismatches();
    int bad = 0;
    first_bad = -1;
    for (int i = 0; i < o_ready.size(); i++)
      if (obs_at(i) !== exp_at(i)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    return bad;
  endfunction

  function automatic int count_obs(input bit which_err);
    int c = 0;
    for (int i = 0; i < o_ready.size(); i++) c += int'(which_err ? o_err[i] : o_ready[i]);
    return c;
  endfunction

  function automatic int first_obs(input bit which_err);
    for (int i = 0; i < o_ready.size(); i++) if (which_err ? o_err[i] : o_ready[i]) return i;
    return -1;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if ({busy, ready, err} !== 3'b000) begin errors++; $display("FAIL release_idle: got %b want 000", {busy, ready, err}); end
  endtask

  task automatic test_single;
    int s, bad;
    line.delete(); add_level(1'b1, 10); s = line.size(); add_frame(8'hA5, 1'b1, BC); add_level(1'b1, 20);
    model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL single_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if (first_obs(1'b0) != s + LAT + 96) begin errors++; $display("FAIL single_ready_time: got %0d want %0d", first_obs(1'b0), s + LAT + 96); end
    checks++; if (o_data[s+LAT+96] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", o_data[s+LAT+96]); end
    checks++; if (count_obs(1'b0) != 1) begin errors++; $display("FAIL single_ready_count: got %0d want 1", count_obs(1'b0)); end
    checks++; if (count_obs(1'b1) != 0) begin errors++; $display("FAIL single_err_count: got %0d want 0", count_obs(1'b1)); end
    cur_data = 8'hA5;
  endtask

  task automatic test_back_to_back;
    int s, bad;
    line.delete(); add_level(1'b1, 10); s = line.size();
    add_frame(8'h3C, 1'b1, BC); add_frame(8'hFF, 1'b1, BC); add_level(1'b1, 20);
    model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if (count_obs(1'b0) != 2) begin errors++; $display("FAIL b2b_ready_count: got %0d want 2", count_obs(1'b0)); end
    checks++; if ({o_ready[s+LAT+96], o_data[s+LAT+96]} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/3c", o_ready[s+LAT+96], o_data[s+LAT+96]); end
    checks++; if ({o_ready[s+LAT+196], o_data[s+LAT+196]} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/ff", o_ready[s+LAT+196], o_data[s+LAT+196]); end
    cur_data = 8'hFF;
  endtask

  task automatic test_glitch;
    int s, bad;
    line.delete(); add_level(1'b1, 10); s = line.size(); add_level(1'b0, 3); add_level(1'b1, 20);
    model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if ({o_busy[s+LAT+HF-1], o_busy[s+LAT+HF]} !== 2'b10) begin errors++; $display("FAIL glitch_busy: got %b want 10", {o_busy[s+LAT+HF-1], o_busy[s+LAT+HF]}); end
    checks++; if (count_obs(1'b0) + count_obs(1'b1) != 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", count_obs(1'b0) + count_obs(1'b1)); end
  endtask

  task automatic test_framing;
    int s, fh, bad;
    line.delete(); add_level(1'b1, 10); s = line.size();
    add_frame(8'h55, 1'b0, BC); add_level(1'b0, 30); fh = line.size(); add_level(1'b1, 20);
    model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL framing_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if (count_obs(1'b1) != 1 || first_obs(1'b1) != s + LAT + 96) begin errors++; $display("FAIL framing_err: got %0d pulses at %0d want 1 at %0d", count_obs(1'b1), first_obs(1'b1), s + LAT + 96); end
    checks++; if (count_obs(1'b0) != 0) begin errors++; $display("FAIL framing_ready: got %0d want 0", count_obs(1'b0)); end
    checks++; if (o_data[line.size()-1] !== cur_data) begin errors++; $display("FAIL framing_data: got %h want %h", o_data[line.size()-1], cur_data); end
    checks++; if ({o_busy[fh+LAT-1], o_busy[fh+LAT]} !== 2'b10) begin errors++; $display("FAIL framing_busy: got %b want 10", {o_busy[fh+LAT-1], o_busy[fh+LAT]}); end
  endtask

  task automatic test_random;
    int bad, nr, ne;
    logic [7:0] b, last;
    bit stop;
    for (int r = 0; r < 3; r++) begin
      line.delete(); add_level(1'b1, 5); nr = 0; ne = 0; last = cur_data;
      for (int f = 0; f < 3; f++) begin
        if ($urandom_range(0, 3) == 0) begin
          add_level(1'b0, $urandom_range(1, 4)); add_level(1'b1, 8);
        end
        b = 8'($urandom); stop = $urandom_range(0, 3) != 0;
        add_frame(b, stop, BC);
        if (stop) begin nr++; last = b; end else ne++;
        add_level(1'b1, stop ? $urandom_range(0, 12) : $urandom_range(1, 12));
      end
      add_level(1'b1, 20);
      model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL random_model[%0d]: %0d bad cycles, first %0d got %h want %h", r, bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
      checks++; if (count_obs(1'b0) != nr || count_obs(1'b1) != ne) begin errors++; $display("FAIL random_counts[%0d]: got %0d/%0d want %0d/%0d", r, count_obs(1'b0), count_obs(1'b1), nr, ne); end
      checks++; if (o_data[line.size()-1] !== last) begin errors++; $display("FAIL random_data[%0d]: got %h want %h", r, o_data[line.size()-1], last); end
      cur_data = last;
    end
  endtask

  task automatic test_reset_midframe;
    int s, bad;
    logic [7:0] b;
    b = 8'h81;
    @(negedge clk); rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BC) @(negedge clk);
    end
    rxd = b[4];
    repeat (HF) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({data, ready, err, busy} !== 11'd0) begin errors++; $display("FAIL midframe_async_reset: got %h want 000", {data, ready, err, busy}); end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cur_data = 8'h00;
    line.delete(); add_level(1'b1, 10); s = line.size(); add_frame(8'h42, 1'b1, BC); add_level(1'b1, 20);
    model(BC, HF, cur_data); run_stream(1'b0); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL after_reset_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if (first_obs(1'b0) != s + LAT + 96 || o_data[line.size()-1] !== 8'h42) begin errors++; $display("FAIL after_reset_frame: got %0d/%h want %0d/42", first_obs(1'b0), o_data[line.size()-1], s + LAT + 96); end
    cur_data = 8'h42;
  endtask

  task automatic test_default;
    int s, bad, t;
    logic [7:0] b;
    b = 8'($urandom);
    line.delete(); add_level(1'b1, 5); s = line.size(); add_frame(b, 1'b1, DBC); add_level(1'b1, 20);
    t = s + LAT + DHF + 9 * DBC + 1;
    model(DBC, DHF, 8'h00); run_stream(1'b1); bad = mismatches();
    checks++; if (bad != 0) begin errors++; $display("FAIL default_model: %0d bad cycles, first %0d got %h want %h", bad, first_bad, obs_at(first_bad), exp_at(first_bad)); end
    checks++; if (first_obs(1'b0) != t || o_data[t] !== b) begin errors++; $display("FAIL default_frame: got %0d/%h want %0d/%h", first_obs(1'b0), o_data[t], t, b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_random();
    test_reset_midframe();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
